// File: rtl/rw_pkg.sv
// rw_pkg: shared walk-engine state encoding, LFSR taps and table-base defaults
package rw_pkg;
  typedef enum logic [2:0] {
    IDLE, RD_FIRST, RD_LAST, RD_NEI, RD_CNT, WR_CNT, END_WALK, DONE
  } rw_state_t;
  // Right-shifting Galois form of the x^32+x^22+x^2+x^1+1 polynomial
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int NEI_ADDR_BASE_DEF = 10;
  localparam int CNT_BASE_DEF = 100;
endpackage

// File: rtl/rw_lfsr32.sv
// rw_lfsr32: free-running 32-bit Galois LFSR; clk, rst_n (async low) in, o_rnd = low 16 state bits out
module rw_lfsr32
  import rw_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2F3B
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_rnd
);
  logic [31:0] r_lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  end
  assign o_rnd = r_lfsr[15:0];
endmodule

// File: rtl/rw_walk_engine.sv
// rw_walk_engine: random-walk engine counting per-(node, step) visits in an external single-port BRAM
// Ports: clk, rst_n (async low); seed_valid/seed_ready/seed_node handshake;
//        mem_addr/mem_we/mem_wdata/mem_rdata BRAM port (read data one cycle after address);
//        busy, done (one-cycle pulse), walks_truncated (walks cut short by zero-degree nodes)
module rw_walk_engine
  import rw_pkg::*;
#(
  parameter int          ADDR_W        = 13,
  parameter int          DATA_W        = 32,
  parameter int          NEI_ADDR_BASE = NEI_ADDR_BASE_DEF,
  parameter int          CNT_BASE      = CNT_BASE_DEF,
  parameter int          MAX_STEPS     = 7,
  parameter int          NUM_WALKS     = 100,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2F3B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [DATA_W-1:0] seed_node,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       walks_truncated
);
  localparam logic [DATA_W-1:0] L_NB  = DATA_W'(NEI_ADDR_BASE);
  localparam logic [DATA_W-1:0] L_CB  = DATA_W'(CNT_BASE);
  localparam logic [DATA_W-1:0] L_MS  = DATA_W'(MAX_STEPS);
  localparam logic [DATA_W-1:0] L_NW  = DATA_W'(NUM_WALKS);
  localparam logic [DATA_W-1:0] L_ONE = DATA_W'(1);

  rw_state_t          r_state;
  logic [DATA_W-1:0]  r_seed, r_curr, r_first, r_nxt, r_step, r_walk;
  logic [ADDR_W-1:0]  r_cnt_addr;
  logic               r_busy, r_done;
  logic [15:0]        r_trunc;
  logic [15:0]        w_rnd;
  logic [DATA_W-1:0]  w_tbl, w_deg, w_idx, w_nei, w_cnt, w_inc;
  logic [DATA_W+15:0] w_prod;

  rw_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .o_rnd(w_rnd));

  // Reads that depend on the word just returned drive the address straight
  // from mem_rdata so each step fits in five cycles.
  assign w_tbl  = L_NB + (r_curr << 1);
  assign w_deg  = (mem_rdata >= r_first) ? mem_rdata - r_first + L_ONE : '0;
  // Scaled multiply maps the 16-bit random value onto 0..deg-1 without a divider
  assign w_prod = {{DATA_W{1'b0}}, w_rnd} * {16'b0, w_deg};
  assign w_idx  = DATA_W'(w_prod >> 16);
  assign w_nei  = r_first + w_idx;
  assign w_cnt  = L_CB + mem_rdata * L_MS + r_step;
  assign w_inc  = (&mem_rdata) ? mem_rdata : mem_rdata + L_ONE;

  always_comb begin
    mem_addr  = (r_state == RD_FIRST) ? ADDR_W'(w_tbl) :
                (r_state == RD_LAST)  ? ADDR_W'(w_tbl + L_ONE) :
                (r_state == RD_NEI)   ? ADDR_W'(w_nei) :
                (r_state == RD_CNT)   ? ADDR_W'(w_cnt) :
                (r_state == WR_CNT)   ? r_cnt_addr : '0;
    mem_we    = (r_state == WR_CNT);
    mem_wdata = mem_we ? w_inc : '0;
  end

  assign seed_ready      = (r_state == IDLE);
  assign busy            = r_busy;
  assign done            = r_done;
  assign walks_truncated = r_trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_seed     <= '0;
      r_curr     <= '0;
      r_first    <= '0;
      r_nxt      <= '0;
      r_step     <= '0;
      r_walk     <= '0;
      r_cnt_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_trunc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (seed_valid) begin
          r_seed  <= seed_node;
          r_curr  <= seed_node;
          r_step  <= '0;
          r_walk  <= '0;
          r_trunc <= '0;
          r_busy  <= 1'b1;
          r_state <= RD_FIRST;
        end
        RD_FIRST: r_state <= RD_LAST;
        RD_LAST: begin
          r_first <= mem_rdata;
          r_state <= RD_NEI;
        end
        RD_NEI: if (w_deg == '0) begin
          r_trunc <= (&r_trunc) ? r_trunc : r_trunc + 16'd1;
          r_state <= END_WALK;
        end else r_state <= RD_CNT;
        RD_CNT: begin
          r_nxt      <= mem_rdata;
          r_cnt_addr <= ADDR_W'(w_cnt);
          r_state    <= WR_CNT;
        end
        WR_CNT: begin
          r_curr  <= r_nxt;
          r_step  <= r_step + L_ONE;
          r_state <= (r_step + L_ONE == L_MS) ? END_WALK : RD_FIRST;
        end
        END_WALK: begin
          r_walk  <= r_walk + L_ONE;
          r_curr  <= r_seed;
          r_step  <= '0;
          r_state <= (r_walk + L_ONE == L_NW) ? DONE : RD_FIRST;
          r_done  <= (r_walk + L_ONE == L_NW);
          r_busy  <= (r_walk + L_ONE != L_NW);
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rw_walk_engine.sv
// tb_rw_walk_engine: scoreboard bench for rw_walk_engine against a walk-level reference model
module tb_rw_walk_engine;
  localparam int NB = 10, CB = 100, M = 3, W = 4;
  localparam logic [31:0] LSEED = 32'hACE1_2F3B;

  logic        clk = 1'b0, rst_n = 1'b1, seed_valid = 1'b0;
  logic [31:0] seed_node = '0;
  logic        seed_ready, mem_we, busy, done;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] walks_truncated;

  logic [31:0] mem [0:8191];
  logic [31:0] rm  [0:8191];
  int checks = 0, failures = 0, cyc = 0, last_done = 0, n_writes = 0, acc_cyc;
  bit prev_hold = 1'b0;

  typedef struct { int a; logic [31:0] d; } wr_t;
  typedef struct { int c; logic [15:0] tr; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  logic [31:0] lc = LSEED;
  int lk = 0;

  always #5 clk = ~clk;

  rw_walk_engine #(.ADDR_W(13), .DATA_W(32), .NEI_ADDR_BASE(NB), .CNT_BASE(CB),
                   .MAX_STEPS(M), .NUM_WALKS(W), .LFSR_SEED(LSEED)) dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_node(seed_node), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .walks_truncated(walks_truncated));

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_at(input int k);
    if (k < lk) begin lc = LSEED; lk = 0; end
    while (lk < k) begin
      lc = lc[0] ? ((lc >> 1) ^ 32'h8020_0003) : (lc >> 1);
      lk++;
    end
    return lc;
  endfunction

  function automatic int ad(input longint unsigned x);
    return int'(x & 64'h1FFF);
  endfunction

  // Walk-level model: walks from the seed, with every state taking one cycle
  // (RD_FIRST at accept+1, RD_NEI two cycles later, five cycles per step,
  // four per truncated walk, one END_WALK cycle per completed walk).
  task automatic model_seed(input logic [31:0] n, input int a);
    int t, ca;
    logic [15:0] tr;
    logic [31:0] v;
    longint unsigned curr, nxt, f, l, deg, idx;
    bit cut;
    t = a + 1;
    tr = '0;
    for (int w = 0; w < W; w++) begin
      curr = n;
      cut = 1'b0;
      for (int s = 0; s < M && !cut; s++) begin
        f = rm[ad(NB + 2 * curr)];
        l = rm[ad(NB + 2 * curr + 1)];
        if (l < f) begin
          cut = 1'b1;
          if (tr != 16'hFFFF) tr++;
          t += 4;
        end else begin
          deg = l - f + 1;
          idx = ((longint'(lfsr_at(t + 2)) & 64'hFFFF) * deg) >> 16;
          nxt = rm[ad(f + idx)];
          ca = ad(CB + nxt * M + s);
          v = rm[ca];
          v = (v == 32'hFFFF_FFFF) ? v : v + 1;
          rm[ca] = v;
          wq.push_back('{ca, v});
          curr = nxt;
          t += 5;
        end
      end
      if (!cut) t += 1;
    end
    dq.push_back('{t, tr});
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("ready_while_busy", {63'b0, seed_ready & busy}, 64'd0);
    if (mem_we) begin
      n_writes++;
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", 64'(mem_wdata), 64'(e.d));
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cycle=%0d", cyc);
      end else begin
        dn_t e;
        e = dq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.c));
        chk("walks_truncated", 64'(walks_truncated), 64'(e.tr));
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        chk("writes_pending", 64'(wq.size()), 64'd0);
      end
      last_done = cyc;
    end
  end

  task automatic setw(input int a, input logic [31:0] v);
    mem[a] = v;
    rm[a] = v;
  endtask

  task automatic set_node(input int n, input int f, input int l);
    setw(NB + 2 * n, 32'(f));
    setw(NB + 2 * n + 1, 32'(l));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) setw(i, '0);
  endtask

  task automatic run_seed(input logic [31:0] n, input bit hold, output int a);
    bit acc;
    acc = 1'b0;
    a = -1;
    seed_node = n;
    seed_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      #1;
      acc = seed_ready;
    end
    chk("seed_accepted", {63'b0, acc}, 64'd1);
    if (acc) begin
      a = cyc;
      if (prev_hold) chk("held_accept_cycle", 64'(a), 64'(last_done + 1));
      model_seed(n, a);
      @(posedge clk);
      #1;
      if (!hold) seed_valid = 1'b0;
      for (int i = 0; i < 5000 && dq.size() > 0; i++) begin
        @(negedge clk);
        #1;
      end
      chk("done_seen", 64'(dq.size()), 64'd0);
      dq.delete();
      wq.delete();
    end
    prev_hold = hold;
  endtask

  task automatic build_fixed();
    clear_mem();
    set_node(1, 1000, 1000); setw(1000, 2);
    set_node(2, 1001, 1001); setw(1001, 3);
    set_node(3, 1002, 1002); setw(1002, 1);
    set_node(4, 1006, 1005);
    set_node(5, 1003, 1003); setw(1003, 6);
    set_node(6, 1004, 1004); setw(1004, 5);
    setw(CB + 6 * M, 32'hFFFF_FFFF);
  endtask

  task automatic build_random();
    int d, r;
    clear_mem();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 4) == 0) set_node(n, 1000 + 8 * n + 1, 1000 + 8 * n);
      else begin
        d = $urandom_range(1, 4);
        set_node(n, 1000 + 8 * n, 1000 + 8 * n + d - 1);
        for (int j = 0; j < d; j++) setw(1000 + 8 * n + j, 32'($urandom_range(0, 7)));
      end
      for (int s = 0; s < M; s++) begin
        r = $urandom_range(0, 9);
        setw(CB + n * M + s, r == 0 ? 32'hFFFF_FFFF : r == 1 ? 32'hFFFF_FFFE : 32'($urandom_range(0, 50)));
      end
    end
  endtask

  initial begin
    int a, lo, hi;
    clear_mem();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_walks_truncated", 64'(walks_truncated), 64'd0);
    chk("rst_seed_ready", {63'b0, seed_ready}, 64'd1);
    build_fixed();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_seed(1, 1'b0, a);
    chk("chain_latency", 64'(last_done - a), 64'd65);
    chk("chain_cnt_2_0", 64'(mem[CB + 2 * M + 0]), 64'd4);
    chk("chain_cnt_3_1", 64'(mem[CB + 3 * M + 1]), 64'd4);
    chk("chain_cnt_1_2", 64'(mem[CB + 1 * M + 2]), 64'd4);
    chk("chain_trunc", 64'(walks_truncated), 64'd0);

    run_seed(4, 1'b0, a);
    chk("trunc_latency", 64'(last_done - a), 64'd17);
    chk("trunc_count", 64'(walks_truncated), 64'd4);

    run_seed(5, 1'b0, a);
    chk("sat_cnt_6_0", 64'(mem[CB + 6 * M + 0]), 64'hFFFF_FFFF);
    chk("sat_cnt_5_1", 64'(mem[CB + 5 * M + 1]), 64'd4);
    chk("sat_cnt_6_2", 64'(mem[CB + 6 * M + 2]), 64'd4);

    clear_mem();
    set_node(1, 1100, 1103);
    for (int k = 2; k <= 5; k++) begin
      setw(1098 + k, 32'(k));
      set_node(k, 1000 + k, 1000 + k);
      setw(1000 + k, 1);
    end
    for (int i = 0; i < 250; i++) run_seed(1, i != 249, a);
    for (int k = 2; k <= 5; k++) begin
      lo = 150;
      hi = 350;
      chk("star_spread", {63'b0, (mem[CB + k * M] >= 32'(lo)) && (mem[CB + k * M] <= 32'(hi))}, 64'd1);
    end

    for (int r = 0; r < 3; r++) begin
      build_random();
      for (int i = 0; i < 6; i++) run_seed(32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)) && i != 5, a);
    end

    build_fixed();
    prev_hold = 1'b0;
    n_writes = 0;
    seed_node = 1;
    seed_valid = 1'b1;
    a = -1;
    for (int i = 0; i < 100 && a < 0; i++) begin
      @(negedge clk);
      #1;
      if (seed_ready) a = cyc;
    end
    chk("rst_test_accept", {63'b0, a >= 0}, 64'd1);
    if (a >= 0) model_seed(1, a);
    for (int i = 0; i < 500 && n_writes < 7; i++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_rst_we", {63'b0, mem_we}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_trunc", 64'(walks_truncated), 64'd0);
    wq.delete();
    dq.delete();
    build_fixed();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_seed(1, 1'b0, a);
    chk("post_rst_accept_cycle", 64'(a), 64'd0);
    chk("post_rst_latency", 64'(last_done - a), 64'd65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
